// File: rtl/monolith_hash_scheduler.sv
// monolith_hash_scheduler
//   Round-robin front end for a single Monolith permutation core. Accepts one
//   state at a time from NUM_REQ requesters, loads it into the core, waits for
//   the core result (or aborts after TIMEOUT_CYCLES RUN cycles), and holds the
//   response until the consumer takes it.
// Ports
//   clk, reset_n            clock, async active-low reset
//   req_valid/req_state     per-requester job offer (held until accepted)
//   req_ready               one-hot grant, combinational, IDLE only
//   resp_valid/resp_ready   response handshake
//   resp_id/resp_state      owner index and permuted state (zeros on timeout)
//   resp_timeout            job aborted by the watchdog
//   core_reset              load strobe to the core (also high during reset)
//   core_state_in/out       state to / result from the core
//   core_valid              core result valid (only honoured in RUN)
//   busy                    FSM not in IDLE
module monolith_hash_scheduler #(
  parameter  int WORD_WIDTH     = 31,
  parameter  int STATE_SIZE     = 16,
  parameter  int NUM_REQ        = 4,
  parameter  int TIMEOUT_CYCLES = 64,
  localparam int ID_W           = $clog2(NUM_REQ)
) (
  input  logic                                                clk,
  input  logic                                                reset_n,
  input  logic [NUM_REQ-1:0]                                  req_valid,
  input  logic [NUM_REQ-1:0][STATE_SIZE-1:0][WORD_WIDTH-1:0]  req_state,
  output logic [NUM_REQ-1:0]                                  req_ready,
  output logic                                                resp_valid,
  input  logic                                                resp_ready,
  output logic [ID_W-1:0]                                     resp_id,
  output logic [STATE_SIZE-1:0][WORD_WIDTH-1:0]               resp_state,
  output logic                                                resp_timeout,
  output logic                                                core_reset,
  output logic [STATE_SIZE-1:0][WORD_WIDTH-1:0]               core_state_in,
  input  logic [STATE_SIZE-1:0][WORD_WIDTH-1:0]               core_state_out,
  input  logic                                                core_valid,
  output logic                                                busy
);

  // One extra bit so the terminal count never wraps.
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_e;

  state_e                                r_state, w_next;
  logic [ID_W-1:0]                       r_rr_ptr, r_job_id;
  logic [TW-1:0]                         r_timer;
  logic [STATE_SIZE-1:0][WORD_WIDTH-1:0] r_job, r_res;
  logic                                  r_to;

  logic [NUM_REQ-1:0]                    w_grant;
  logic [ID_W-1:0]                       w_idx, w_gidx;
  logic                                  w_found, w_hs, w_tmo;

  // Rotating priority search starting at r_rr_ptr. Grant is suppressed while
  // reset is asserted so req_ready reads zero during reset.
  always_comb begin
    w_grant = '0;
    w_idx   = '0;
    w_gidx  = '0;
    w_found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = ID_W'((int'(r_rr_ptr) + k) % NUM_REQ);
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_gidx  = w_idx;
      end
    end
    if (w_found && r_state == IDLE && reset_n) w_grant[w_gidx] = 1'b1;
  end

  assign w_hs  = |w_grant;
  assign w_tmo = (r_timer == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_hs) w_next = LOAD;
      LOAD:    w_next = RUN;
      RUN:     if (core_valid || w_tmo) w_next = RESP;
      RESP:    if (resp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rr_ptr <= '0;
      r_job_id <= '0;
      r_timer  <= '0;
      r_job    <= '0;
      r_res    <= '0;
      r_to     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_hs) begin
          r_job    <= req_state[w_gidx];
          r_job_id <= w_gidx;
        end
        LOAD: r_timer <= '0;
        RUN: begin
          r_timer <= r_timer + TW'(1);
          // core_valid has priority over the watchdog in the same cycle
          if (core_valid) begin
            r_res <= core_state_out;
            r_to  <= 1'b0;
          end else if (w_tmo) begin
            r_res <= '0;
            r_to  <= 1'b1;
          end
        end
        RESP: if (resp_ready)
          r_rr_ptr <= (r_job_id == ID_W'(NUM_REQ - 1)) ? '0 : r_job_id + ID_W'(1);
        default: ;
      endcase
    end
  end

  assign req_ready     = w_grant;
  assign core_state_in = r_job;
  assign resp_valid    = (r_state == RESP);
  assign resp_state    = r_res;
  assign resp_id       = r_job_id;
  assign resp_timeout  = r_to & resp_valid;
  assign busy          = (r_state != IDLE);
  // Core is held in reset while the block is in reset, so an aborted job
  // leaves nothing running in the core.
  assign core_reset    = ~reset_n | (r_state == LOAD);

endmodule

// File: tb/tb_monolith_hash_scheduler.sv
module tb_monolith_hash_scheduler;
  localparam int W  = 31;
  localparam int SS = 16;
  localparam int NR = 4;
  localparam int TO = 64;
  localparam int IW = $clog2(NR);

  typedef logic [SS-1:0][W-1:0] st_t;

  logic               clk = 1'b0;
  logic               reset_n;
  logic [NR-1:0]      req_valid;
  logic [NR-1:0][SS-1:0][W-1:0] req_state;
  logic [NR-1:0]      req_ready;
  logic               resp_valid, resp_ready, resp_timeout, core_reset, core_valid, busy;
  logic [IW-1:0]      resp_id;
  st_t                resp_state, core_state_in, core_state_out;

  monolith_hash_scheduler #(.WORD_WIDTH(W), .STATE_SIZE(SS), .NUM_REQ(NR), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_state(req_state),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_state(resp_state), .resp_timeout(resp_timeout),
    .core_reset(core_reset), .core_state_in(core_state_in),
    .core_state_out(core_state_out), .core_valid(core_valid), .busy(busy));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- hash core model ----------------
  // Loads on core_reset, raises core_valid for one cycle on the core_delay-th
  // cycle afterwards (core_delay==0: never). Output is garbage when not valid.
  int  core_delay;
  int  cm_cnt, cm_delay;
  bit  cm_act;
  st_t cm_out;

  function automatic st_t core_f(input st_t s);
    st_t r;
    for (int i = 0; i < SS; i++) r[i] = s[i] * W'(5) + W'(3 * i + 1);
    return r;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cm_act <= 1'b0;
    else if (core_reset) begin
      cm_act <= 1'b1; cm_cnt <= 0; cm_delay <= core_delay; cm_out <= core_f(core_state_in);
    end else if (cm_act) cm_cnt <= cm_cnt + 1;
  end
  assign core_valid     = cm_act && (cm_delay != 0) && (cm_cnt == cm_delay - 1);
  assign core_state_out = core_valid ? cm_out : ~cm_out;

  // ---------------- checking ----------------
  int pass_cnt = 0, total_cnt = 0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic int exp_grant(input logic [NR-1:0] v, input int rr);
    for (int k = 0; k < NR; k++) if (v[(rr + k) % NR]) return (rr + k) % NR;
    return -1;
  endfunction

  // Transaction-level model: a job accepted at sample cycle H shows core_reset
  // at H+1 and its response from H+2+N, N = core delay or TO on abort.
  bit            m_busy = 0;
  int            m_rr = 0, m_hs, m_id, m_resp_at, last_lat, resp_cycles;
  bit            m_to, last_to;
  st_t           m_job, m_exp, last_exp;
  int            n_resp = 0, n_done = 0;
  int            glog[$];
  logic [NR-1:0] acc_mask;

  always @(negedge clk) begin
    logic [NR-1:0] er;
    int g;
    acc_mask = '0;
    if (!reset_n) begin
      chk("rst_core_reset", core_reset, 1);
      chk("rst_busy", busy, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_timeout", resp_timeout, 0);
      chk("rst_core_state_in", core_state_in, 0);
      m_busy = 0; m_rr = 0;
    end else if (!m_busy) begin
      g  = exp_grant(req_valid, m_rr);
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      chk("idle_req_ready", req_ready, er);
      chk("idle_busy", busy, 0);
      chk("idle_resp_valid", resp_valid, 0);
      chk("idle_core_reset", core_reset, 0);
      if (g >= 0) begin
        m_busy = 1; m_hs = cyc; m_id = g; m_job = req_state[g];
        acc_mask = er; glog.push_back(g);
      end
    end else begin
      chk("job_busy", busy, 1);
      chk("job_req_ready", req_ready, 0);
      chk("job_core_state_in", core_state_in, m_job);
      if (cyc == m_hs + 1) begin
        chk("load_core_reset", core_reset, 1);
        chk("load_resp_valid", resp_valid, 0);
        m_to      = !(core_delay >= 1 && core_delay <= TO);
        m_resp_at = m_hs + 2 + (m_to ? TO : core_delay);
        m_exp     = m_to ? st_t'(0) : core_f(m_job);
      end else begin
        chk("job_core_reset", core_reset, 0);
        if (cyc < m_resp_at) chk("run_resp_valid", resp_valid, 0);
        else begin
          chk("resp_valid", resp_valid, 1);
          chk("resp_id", resp_id, m_id);
          chk("resp_state", resp_state, m_exp);
          chk("resp_timeout", resp_timeout, m_to);
          if (cyc == m_resp_at) begin
            last_lat = cyc - m_hs; last_to = m_to; last_exp = m_exp; n_resp++;
          end
          if (resp_ready) begin
            m_busy = 0; m_rr = (m_id + 1) % NR;
            resp_cycles = cyc - m_resp_at + 1; n_done++;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  bit            rand_mode = 0;
  logic [NR-1:0] refill = '0;

  task automatic raise(input int i);
    for (int w = 0; w < SS; w++) req_state[i][w] = W'($urandom);
    req_valid[i] = 1'b1;
  endtask

  task automatic step();
    @(posedge clk); #1;
    for (int i = 0; i < NR; i++) if (acc_mask[i]) req_valid[i] = 1'b0;
    if (rand_mode) begin
      for (int i = 0; i < NR; i++) if (!req_valid[i] && $urandom_range(2) == 0) raise(i);
      resp_ready = ($urandom_range(3) != 0);
      core_delay = ($urandom_range(7) == 0) ? 0 : 1 + int'($urandom_range(69));
    end else
      for (int i = 0; i < NR; i++) if (refill[i] && !req_valid[i]) raise(i);
  endtask

  task automatic wait_done(input int target);
    int k = 0;
    while (n_done < target && k < 400) begin step(); k++; end
    chk("wait_done_in_budget", n_done >= target, 1);
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((req_valid != 0 || m_busy) && k < 3000) begin step(); k++; end
    chk("drain_in_budget", (req_valid == 0) && !m_busy, 1);
  endtask

  initial begin
    int n0, g0, k;
    reset_n = 0; req_valid = '0; req_state = '0; resp_ready = 1; core_delay = 20;
    repeat (3) step();
    reset_n = 1;

    // single job from requester 2, words 0..15, core answers after 20 cycles
    for (int w = 0; w < SS; w++) req_state[2][w] = W'(w);
    req_valid[2] = 1; core_delay = 20;
    n0 = n_done; g0 = glog.size();
    wait_done(n0 + 1);
    chk("lit_single_grant", glog[g0], 2);
    chk("lit_single_latency", last_lat, 22);
    chk("lit_single_timeout", last_to, 0);
    chk("lit_model_w0", last_exp[0], 1);
    chk("lit_model_w15", last_exp[15], 121);

    // round robin after reset with every requester always offering
    reset_n = 0; refill = '1; core_delay = 3;
    repeat (3) step();
    reset_n = 1; g0 = glog.size(); k = 0;
    while (glog.size() < g0 + 5 && k < 500) begin step(); k++; end
    chk("rr_in_budget", glog.size() >= g0 + 5, 1);
    for (int i = 0; i < 5; i++) if (glog.size() > g0 + i) chk("lit_rr_order", glog[g0 + i], i % NR);
    refill = '0;
    wait_idle();

    // backpressure: resp_ready low for the first 10 RESP cycles
    resp_ready = 0; core_delay = 4; raise(1);
    n0 = n_resp; k = 0;
    while (n_resp == n0 && k < 200) begin step(); k++; end
    repeat (9) step();
    resp_ready = 1; n0 = n_done;
    wait_done(n0 + 1);
    chk("lit_backpressure_cycles", resp_cycles, 11);

    // timeout, then a normal job
    core_delay = 0; raise(3); wait_done(n_done + 1);
    chk("lit_timeout_latency", last_lat, 66);
    chk("lit_timeout_flag", last_to, 1);
    core_delay = 5; raise(0); wait_done(n_done + 1);
    chk("lit_after_timeout_latency", last_lat, 7);
    chk("lit_after_timeout_flag", last_to, 0);

    // boundary: result at timer==63 wins, one later aborts
    core_delay = 64; raise(1); wait_done(n_done + 1);
    chk("lit_boundary_latency", last_lat, 66);
    chk("lit_boundary_flag", last_to, 0);
    core_delay = 65; raise(2); wait_done(n_done + 1);
    chk("lit_past_boundary_flag", last_to, 1);

    // reset during RUN cycle 5
    core_delay = 30; raise(2); k = 0;
    while (!m_busy && k < 50) begin step(); k++; end
    while (m_busy && cyc < m_hs + 6 && k < 100) begin step(); k++; end
    chk("midrun_reached", m_busy && cyc == m_hs + 6, 1);
    reset_n = 0; refill = '1; n0 = n_resp;
    repeat (3) step();
    reset_n = 1; g0 = glog.size(); k = 0;
    while (glog.size() == g0 && k < 20) begin step(); k++; end
    if (glog.size() > g0) chk("lit_after_reset_grant", glog[g0], 0);
    else chk("after_reset_grant_seen", 0, 1);
    chk("midrun_no_response", n_resp, n0);
    refill = '0;
    wait_idle();

    // randomized traffic
    rand_mode = 1;
    repeat (3000) step();
    rand_mode = 0; resp_ready = 1;
    wait_idle();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/monolith_hash_scheduler.md
MONOLITH_HASH_SCHEDULER -- requirements
Module: monolith_hash_scheduler

Interface
REQ-001 Parameter WORD_WIDTH, default 31: field element width in bits.
REQ-002 Parameter STATE_SIZE, default 16: words per permutation state.
REQ-003 Parameter NUM_REQ, default 4: number of requester ports, minimum 2.
REQ-004 Parameter TIMEOUT_CYCLES, default 64: maximum RUN cycles before a job is aborted.
REQ-005 Localparam ID_W = $clog2(NUM_REQ).
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 reset_n  in  1  reset, asynchronous, active-low.
REQ-008 req_valid  in  [NUM_REQ]  requester i has a state to hash.
REQ-009 req_state  in  [NUM_REQ][STATE_SIZE] x WORD_WIDTH  per-requester input state.
REQ-010 req_ready  out  [NUM_REQ]  job accepted from requester i this cycle.
REQ-011 resp_valid  out  1  result available.
REQ-012 resp_ready  in  1  consumer accepts result.
REQ-013 resp_id  out  ID_W  index of the requester that owns the result.
REQ-014 resp_state  out  [STATE_SIZE] x WORD_WIDTH  permuted state.
REQ-015 resp_timeout  out  1  job aborted; resp_state is all zeros.
REQ-016 core_reset  out  1  active-high synchronous reset/load strobe to the hash core.
REQ-017 core_state_in  out  [STATE_SIZE] x WORD_WIDTH  state presented to the core.
REQ-018 core_state_out  in  [STATE_SIZE] x WORD_WIDTH  core result.
REQ-019 core_valid  in  1  core result valid.
REQ-020 busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-021 The FSM SHALL have states IDLE, LOAD, RUN and RESP.
REQ-022 IDLE: the grant SHALL be the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ; req_ready SHALL be one-hot on the grant, combinationally, and all zeros when no req_valid is set.
REQ-023 On a req_valid[g] & req_ready[g] handshake: req_state[g] SHALL be latched into job_reg, g SHALL be latched into job_id, and the next state SHALL be LOAD.
REQ-024 core_state_in SHALL equal job_reg continuously; job_reg SHALL be stable from LOAD until the next accepted job.
REQ-025 LOAD: core_reset=1 for exactly one cycle; the timer SHALL be cleared to 0; the next state SHALL be RUN.
REQ-026 core_reset SHALL be 0 in IDLE, RUN and RESP.
REQ-027 RUN: the timer SHALL increment each cycle; core_valid=1 SHALL capture core_state_out into res_reg, clear the timeout flag, and go to RESP.
REQ-028 RUN: if core_valid=0 and timer==TIMEOUT_CYCLES-1, the block SHALL set res_reg=0, set the timeout flag, and go to RESP; when both occur in the same cycle, core_valid wins.
REQ-029 core_valid SHALL be ignored in IDLE, LOAD and RESP.
REQ-030 Latency SHALL be 1 (LOAD) + N + 1 cycles from handshake to resp_valid, where N is the number of RUN cycles until core_valid is seen.
REQ-031 RESP: resp_valid=1; resp_state, resp_id and resp_timeout SHALL be driven from registers and held stable until resp_ready=1.
REQ-032 RESP with resp_ready=1: rr_ptr SHALL become (job_id+1) mod NUM_REQ, and the next state SHALL be IDLE; no new job is accepted in that same cycle.
REQ-033 req_ready SHALL be all zeros outside IDLE; requesters hold req_valid and req_state until accepted.
REQ-034 The timer SHALL be ceil(log2(TIMEOUT_CYCLES))+1 bits wide and SHALL never wrap.

Reset
REQ-035 While reset_n=0: state=IDLE, rr_ptr=0, job_id=0, timer=0, job_reg=0, res_reg=0, timeout flag=0; outputs req_ready=0, resp_valid=0, resp_timeout=0, busy=0, core_reset=1.
REQ-036 Assertion of reset_n mid-job SHALL abort the job immediately, with no response emitted.
REQ-037 After reset_n deasserts, operation SHALL resume from IDLE on the first clk edge.

Verification
REQ-038 Single job: req_valid[2]=1 with state words 0..15 and a core model that raises core_valid 20 cycles after core_reset -> one req_ready[2] pulse, core_reset high 1 cycle, resp_valid 22 cycles after the handshake, resp_id=2, resp_state equal to the model output.
REQ-039 Round robin: all four req_valid held high -> grants in order 0,1,2,3,0; no requester granted twice before the others.
REQ-040 Backpressure: resp_ready=0 for 10 cycles in RESP -> resp_valid, resp_state and resp_id stable; req_ready=0 throughout; busy=1.
REQ-041 Timeout: core_valid never asserted, TIMEOUT_CYCLES=64 -> resp_valid after 1+64+1 cycles with resp_timeout=1 and resp_state all zeros; the next job completes normally with resp_timeout=0.
REQ-042 Boundary: core_valid asserted exactly at timer=63 -> the result is captured and resp_timeout=0.
REQ-043 Reset mid-RUN: reset_n=0 for 3 cycles at RUN cycle 5 -> core_reset=1 and busy=0 immediately, no resp_valid, rr_ptr=0, and requester 0 granted first afterwards.
